// File: rtl/adc_pb_pkg.sv
// rtl/adc_pb_pkg.sv - shared types and helpers for the ADC playback sequencer
package adc_pb_pkg;

   localparam int SAMPLE_W   = 16;
   localparam int RD_LAT_DEF = 2;
   localparam int FDEPTH     = RD_LAT_DEF + 2;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic [SAMPLE_W-1:0] data;
      logic                last;
   } sample_t;

   // Credit pool: every in-flight read must have a FIFO slot waiting for it
   function automatic int fifo_depth(input int rd_lat);
      return rd_lat + 2;
   endfunction

endpackage

// File: rtl/adc_playback_ctrl_if.sv
// rtl/adc_playback_ctrl_if.sv - sample memory read port plus downstream sample stream
interface adc_playback_ctrl_if #(
   parameter int AW = 15,
   parameter int DW = 16
);
   logic [AW-1:0] mem_addr;
   logic          mem_rd_en;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] sample_data;
   logic          sample_valid;
   logic          sample_ready;
   logic          sample_last;

   modport master (
      output mem_addr, mem_rd_en, sample_data, sample_valid, sample_last,
      input  mem_rdata, sample_ready
   );

   modport slave (
      input  mem_addr, mem_rd_en, sample_data, sample_valid, sample_last,
      output mem_rdata, sample_ready
   );
endinterface

// File: rtl/adc_playback_ctrl_sample_fifo.sv
// rtl/adc_playback_ctrl_sample_fifo.sv - show-ahead FIFO of tagged samples
module sample_fifo
   import adc_pb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  sample_t       i_wdata,
   input  logic          i_pop,
   output sample_t       o_rdata,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);
   localparam int PW = $clog2(DEPTH);

   sample_t         r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            w_push;
   logic            w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   // A push into a full FIFO is legal when the head leaves in the same cycle
   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
         end
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/adc_playback_ctrl.sv
// rtl/adc_playback_ctrl.sv - rate-paced sample memory reader with credit-limited output FIFO
module adc_playback_ctrl
   import adc_pb_pkg::*;
#(
   parameter int DEPTH  = 31000,
   parameter int DATA_W = SAMPLE_W,
   parameter int DIV_W  = 16,
   parameter int RD_LAT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic               i_loop_en,
   input  logic [DIV_W-1:0]   i_rate_div,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_overrun,
   adc_playback_ctrl_if.master io_pb
);
   localparam int AW    = $clog2(DEPTH);
   localparam int FD    = fifo_depth(RD_LAT);
   localparam int CW    = $clog2(FD + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t              r_state;
   logic [AW-1:0]       r_addr;
   logic [DIV_W-1:0]    r_rate;
   logic [DIV_W-1:0]    r_tick;
   logic                r_loop;
   logic                r_overrun;
   logic                r_busy;
   logic [RD_LAT-1:0]   r_pipe_v;
   logic [RD_LAT-1:0]   r_pipe_last;

   logic [CW-1:0]       w_inflight;
   logic [CW-1:0]       w_fcount;
   logic                w_full;
   logic                w_empty;
   logic                w_tick;
   logic                w_credit;
   logic                w_rd_en;
   logic                w_drained;
   logic                w_pop;
   sample_t             w_wdata;
   sample_t             w_rdata;

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CW'(r_pipe_v[i]);
   end

   assign w_tick    = (r_state == RUN) && (r_tick == r_rate);
   assign w_credit  = ({1'b0, w_inflight} + {1'b0, w_fcount}) < (CW + 1)'(FD);
   assign w_rd_en   = w_tick && w_credit;
   assign w_drained = (w_inflight == '0) && w_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_rate    <= '0;
         r_tick    <= '0;
         r_loop    <= 1'b0;
         r_overrun <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start && !i_stop) begin
                  r_state   <= RUN;
                  r_loop    <= i_loop_en;
                  r_rate    <= i_rate_div;
                  r_tick    <= i_rate_div;
                  r_addr    <= '0;
                  r_overrun <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            RUN: begin
               r_tick <= w_tick ? '0 : r_tick + DIV_W'(1);
               if (w_tick && !w_credit) r_overrun <= 1'b1;
               if (w_rd_en) begin
                  if (r_addr == LAST_ADDR) begin
                     r_addr <= '0;
                     if (!r_loop) r_state <= DRAIN;
                  end else begin
                     r_addr <= r_addr + AW'(1);
                  end
               end
               if (i_stop) r_state <= DRAIN;
            end
            DRAIN: begin
               if (w_drained) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Each read carries its end-of-table tag through the latency pipe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pipe_v    <= '0;
         r_pipe_last <= '0;
      end else begin
         r_pipe_v[0]    <= w_rd_en;
         r_pipe_last[0] <= w_rd_en && (r_addr == LAST_ADDR);
         for (int i = 1; i < RD_LAT; i++) begin
            r_pipe_v[i]    <= r_pipe_v[i-1];
            r_pipe_last[i] <= r_pipe_last[i-1];
         end
      end
   end

   assign w_wdata.data = io_pb.mem_rdata[DATA_W-1:0];
   assign w_wdata.last = r_pipe_last[RD_LAT-1];
   assign w_pop        = !w_empty && io_pb.sample_ready;

   sample_fifo #(.DEPTH(FD), .CW(CW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_pipe_v[RD_LAT-1]),
      .i_wdata (w_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_fcount)
   );

   assign io_pb.mem_addr     = r_addr;
   assign io_pb.mem_rd_en    = w_rd_en;
   assign io_pb.sample_data  = w_rdata.data[DATA_W-1:0];
   assign io_pb.sample_valid = !w_empty;
   assign io_pb.sample_last  = w_rdata.last && !w_empty;
   assign o_busy             = r_busy;
   assign o_done             = (r_state == DRAIN) && w_drained;
   assign o_overrun          = r_overrun;

   logic w_unused;
   assign w_unused = w_full;
endmodule

// File: tb/tb_adc_playback_ctrl.sv
// tb/tb_adc_playback_ctrl.sv - randomized playback scenarios against a sequence-level model
module tb_adc_playback_ctrl;
   localparam int DEPTH  = 8;
   localparam int DATA_W = 16;

   logic        clk;
   logic        rst;
   logic        i_start;
   logic        i_stop;
   logic        i_loop_en;
   logic [15:0] i_rate_div;
   logic        o_busy;
   logic        o_done;
   logic        o_overrun;

   adc_playback_ctrl_if #(.AW(3), .DW(DATA_W)) pb ();

   adc_playback_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DIV_W(16), .RD_LAT(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .i_stop     (i_stop),
      .i_loop_en  (i_loop_en),
      .i_rate_div (i_rate_div),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_overrun  (o_overrun),
      .io_pb      (pb)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_d1, rd_d2;

   int          rd_log [$];
   int          rd_cyc [$];
   logic [16:0] got [$];
   int          first_valid_cyc, last_xfer_cyc, done_cyc, done_cnt;
   bit          prev_stall;
   logic [15:0] prev_data;
   logic        prev_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory with two cycles of read latency
   always @(posedge clk) begin
      rd_d1 <= pb.mem_rd_en ? mem[pb.mem_addr] : 16'hDEAD;
      rd_d2 <= rd_d1;
   end
   assign pb.mem_rdata = rd_d2;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (pb.mem_rd_en) begin
            rd_log.push_back(int'(pb.mem_addr));
            rd_cyc.push_back(cyc);
         end
         if (pb.sample_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (prev_stall) begin
            check("hold_valid", pb.sample_valid, 1);
            check("hold_data", pb.sample_data, prev_data);
            check("hold_last", pb.sample_last, prev_last);
         end
         if (pb.sample_valid && pb.sample_ready) begin
            got.push_back({pb.sample_last, pb.sample_data});
            last_xfer_cyc = cyc;
         end
         if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_stall = pb.sample_valid && !pb.sample_ready;
         prev_data  = pb.sample_data;
         prev_last  = pb.sample_last;
      end
   end

   task automatic clear_logs();
      rd_log.delete();
      rd_cyc.delete();
      got.delete();
      first_valid_cyc = -1;
      last_xfer_cyc   = -1;
      done_cyc        = -1;
      done_cnt        = 0;
   endtask

   // mode: 0 ready always high, 1 random ready, 2 ready low for the first 10 cycles
   task automatic run_case(input bit lp, input int rate, input int stop_after, input int mode,
                           input bit poke, input bit ov_known, input bit ov_exp);
      int t0, k, n;
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
      clear_logs();
      n = (stop_after != 0) ? stop_after : DEPTH;
      i_loop_en = lp;
      i_rate_div = 16'(rate);
      i_start = 1'b1;
      i_stop = 1'b0;
      pb.sample_ready = (mode == 0);
      t0 = cyc;
      @(posedge clk); #1;
      i_start = 1'b0;
      check("busy_rise", o_busy, 1);
      k = 0;
      while (done_cyc < 0 && k < 3000) begin
         if (mode == 2 && cyc == t0 + 11) begin
            check("stall_reads", rd_log.size(), 4);
            check("overrun_set", o_overrun, 1);
         end
         case (mode)
            0:       pb.sample_ready = 1'b1;
            1:       pb.sample_ready = ($urandom_range(0, 3) != 0);
            default: pb.sample_ready = (cyc > t0 + 10);
         endcase
         i_stop = (stop_after != 0) && pb.mem_rd_en && (rd_log.size() == stop_after - 1);
         if (poke && cyc == t0 + 5) begin
            i_start = 1'b1;
            i_loop_en = 1'b1;
            i_rate_div = 16'd7;
         end else begin
            i_start = 1'b0;
         end
         @(posedge clk); #1;
         k++;
      end
      i_stop = 1'b0;
      i_start = 1'b0;
      if (done_cyc < 0) check("timeout", 0, 1);
      else check("busy_fall", o_busy, 0);

      check("n_reads", rd_log.size(), n);
      for (int i = 0; i < n && i < rd_log.size(); i++) check("rd_addr", rd_log[i], i % DEPTH);
      check("n_samples", got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++) begin
         check("sample_data", got[i][15:0], mem[i % DEPTH]);
         check("sample_last", got[i][16], (i % DEPTH) == DEPTH - 1);
      end
      if (rd_cyc.size() > 0) begin
         check("first_rd_cyc", rd_cyc[0], t0 + 1);
         check("first_valid_lat", first_valid_cyc, rd_cyc[0] + 3);
      end
      if (mode == 0)
         for (int i = 1; i < rd_cyc.size(); i++) check("rd_spacing", rd_cyc[i] - rd_cyc[i-1], rate + 1);
      check("done_width", done_cnt, 1);
      check("done_after_last", done_cyc, last_xfer_cyc + 1);
      if (ov_known) check("overrun_end", o_overrun, ov_exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"}, pb.mem_addr, 0);
      check({tag, "_rd_en"}, pb.mem_rd_en, 0);
      check({tag, "_data"}, pb.sample_data, 0);
      check({tag, "_valid"}, pb.sample_valid, 0);
      check({tag, "_last"}, pb.sample_last, 0);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_done"}, o_done, 0);
      check({tag, "_overrun"}, o_overrun, 0);
   endtask

   initial begin
      rst = 1'b1;
      i_start = 1'b0;
      i_stop = 1'b0;
      i_loop_en = 1'b0;
      i_rate_div = '0;
      pb.sample_ready = 1'b0;
      clear_logs();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      run_case(0, 0, 0, 0, 0, 1, 0);
      run_case(0, 3, 0, 0, 0, 1, 0);
      run_case(1, 0, 20, 0, 0, 1, 0);
      run_case(0, 0, 0, 2, 0, 1, 1);

      // Reset with two reads in flight
      clear_logs();
      i_loop_en = 1'b0;
      i_rate_div = '0;
      pb.sample_ready = 1'b1;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_reads", rd_log.size(), 2);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrun");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_case(0, 0, 0, 0, 0, 1, 0);

      // start and stop together in IDLE
      clear_logs();
      i_start = 1'b1;
      i_stop = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      i_stop = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("startstop_busy", o_busy, 0);
         @(posedge clk); #1;
      end
      check("startstop_reads", rd_log.size(), 0);

      run_case(0, 0, 0, 0, 1, 1, 0);

      for (int r = 0; r < 6; r++) begin
         bit lp;
         int rate, sa;
         lp = 1'($urandom_range(0, 1));
         rate = $urandom_range(0, 4);
         if (lp) sa = $urandom_range(3, 20);
         else sa = ($urandom_range(0, 1) != 0) ? $urandom_range(3, 8) : 0;
         run_case(lp, rate, sa, 1, 0, 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
